// File: rtl/pac_sprite_fetch.sv
// Sprite line prefetch: on line_start, reads one 24-pixel row of the sprite ROM into a line buffer.
// pix_on then flags lit sprite pixels for scan_x. Define PAC_FETCH_DIR_HOLD_EN so that only one-hot directions are latched.
module pac_sprite_fetch (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_start,
    input  logic [9:0] scan_y,
    input  logic [9:0] scan_x,
    input  logic [9:0] pac_x,
    input  logic [9:0] pac_y,
    input  logic [3:0] direction,
    output logic [4:0] rom_x,
    output logic [4:0] rom_y,
    output logic [3:0] rom_dir,
    input  logic       rom_pixel,
    output logic       busy,
    output logic       pix_on
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    // Bind point for state checkers.
    state_t      state;
    logic [4:0]  col_d;
    logic        valid_d;
    logic [23:0] line_buf;

    logic [10:0] row;
    logic [10:0] dx;
    logic        row_hit;
    logic        x_hit;
    logic        dir_ok;

    // The 11-bit signed differences keep sprites near 1023 from wrapping onto column/row 0.
    assign row     = {1'b0, scan_y} - {1'b0, pac_y};
    assign dx      = {1'b0, scan_x} - {1'b0, pac_x};
    assign row_hit = !row[10] && (row <= 11'd23);
    assign x_hit   = !dx[10] && (dx <= 11'd23);

`ifdef PAC_FETCH_DIR_HOLD_EN
    assign dir_ok = (direction != 4'd0) && ((direction & (direction - 4'd1)) == 4'd0);
`else
    assign dir_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            col_d    <= 5'd0;
            valid_d  <= 1'b0;
            line_buf <= 24'd0;
            rom_x    <= 5'd0;
            rom_y    <= 5'd0;
            rom_dir  <= 4'd0;
            busy     <= 1'b0;
            pix_on   <= 1'b0;
        end else begin
            valid_d <= 1'b0;
            col_d   <= rom_x;
            pix_on  <= 1'b0;
            if (valid_d) begin
                line_buf[col_d] <= rom_pixel;
            end

            if (line_start) begin
                // Clearing the buffer also discards the pixel still returning from an aborted fetch.
                line_buf <= 24'd0;
                rom_x    <= 5'd0;
                if (row_hit) begin
                    state <= FETCH;
                    busy  <= 1'b1;
                    rom_y <= row[4:0];
                    if (dir_ok) begin
                        rom_dir <= direction;
                    end
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rom_y <= 5'd0;
                    if (state == IDLE) begin
                        pix_on <= x_hit && line_buf[dx[4:0]];
                    end
                end
            end else begin
                case (state)
                    IDLE: begin
                        pix_on <= x_hit && line_buf[dx[4:0]];
                    end
                    FETCH: begin
                        valid_d <= 1'b1;
                        if (rom_x == 5'd23) begin
                            state <= DRAIN;
                            rom_x <= 5'd0;
                        end else begin
                            rom_x <= rom_x + 5'd1;
                        end
                    end
                    DRAIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        rom_y <= 5'd0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
